// File: rtl/mac_mgnt_pkg.sv
// Shared definitions for the MAC management poller: FSM states, address
// field layout and statistics counter index map.
package mac_mgnt_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ_LO,
    S_WAIT_LO,
    S_REQ_HI,
    S_WAIT_HI,
    S_ACC,
    S_NEXT
  } state_e;

  localparam int unsigned ADDR_IDX_MSB = 7;
  localparam int unsigned ADDR_IDX_LSB = 1;
  localparam int unsigned ADDR_BSEL    = 0;

  localparam logic BSEL_LO = 1'b0;
  localparam logic BSEL_HI = 1'b1;

  localparam int unsigned CNT_RX_FRAMES = 0;
  localparam int unsigned CNT_RX_ERR    = 1;
  localparam int unsigned CNT_TX_FRAMES = 2;
  localparam int unsigned CNT_TX_DROP   = 3;

endpackage

// File: rtl/mgnt_cnt_bank.sv
// Per-counter last-sample and 32-bit total registers with wrap-corrected
// delta accumulation, bulk clear and a registered host read port.
module mgnt_cnt_bank #(
  parameter int unsigned NUM_CNT = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic             clk,
  input  logic             rstn_sys,
  input  logic             clr,
  input  logic             acc_en,
  input  logic [IDX_W-1:0] acc_idx,
  input  logic [15:0]      acc_new,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_data
);

  logic [15:0] last_q  [NUM_CNT];
  logic [15:0] last_d  [NUM_CNT];
  logic [31:0] total_q [NUM_CNT];
  logic [31:0] total_d [NUM_CNT];
  logic [31:0] rd_data_q;
  logic [15:0] delta;

  always_comb begin
    last_d  = last_q;
    total_d = total_q;
    delta   = acc_new - last_q[acc_idx];
    if (acc_en) begin
      last_d[acc_idx]  = acc_new;
      total_d[acc_idx] = total_q[acc_idx] + {16'b0, delta};
    end
    // Clear overrides the accumulate but leaves last[] so deltas stay continuous.
    if (clr) begin
      for (int unsigned i = 0; i < NUM_CNT; i++) begin
        total_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn_sys) begin
    if (!rstn_sys) begin
      for (int unsigned i = 0; i < NUM_CNT; i++) begin
        last_q[i]  <= '0;
        total_q[i] <= '0;
      end
      rd_data_q <= '0;
    end else begin
      last_q    <= last_d;
      total_q   <= total_d;
      rd_data_q <= total_d[rd_idx];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/mac_mgnt_poller.sv
// Periodic statistics sweeper for the MAC management byte interface: reads
// each 16-bit counter as two bytes and accumulates deltas into 32-bit totals.
module mac_mgnt_poller
  import mac_mgnt_pkg::*;
#(
  parameter int unsigned NUM_CNT     = 4,
  parameter int unsigned IDX_W       = 2,
  parameter int unsigned POLL_PERIOD = 125000,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic             clk,
  input  logic             rstn_sys,
  output logic             sys_req_valid,
  output logic             sys_req_wr,
  output logic [7:0]       sys_req_addr,
  input  logic             sys_resp_valid,
  input  logic [7:0]       sys_resp_data,
  input  logic             poll_en,
  input  logic             poll_kick,
  input  logic             host_clr,
  input  logic [IDX_W-1:0] host_rd_idx,
  output logic [31:0]      host_rd_data,
  output logic             busy,
  output logic             sweep_done,
  output logic             timeout_err
);

  localparam int unsigned PW = (POLL_PERIOD > 2) ? $clog2(POLL_PERIOD) : 1;
  localparam int unsigned WW = $clog2(TIMEOUT) + 1;

  state_e           state_q, state_d;
  logic             pend_q, pend_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       lo_q, lo_d, hi_q, hi_d;
  logic [PW-1:0]    per_q, per_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic             req_valid_q, req_valid_d;
  logic [7:0]       req_addr_q, req_addr_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             terr_q, terr_d;
  logic             tick;
  logic             take;

  always_comb begin
    tick  = 1'b0;
    per_d = per_q;
    if (!poll_en) begin
      per_d = '0;
    end else if (per_q == PW'(POLL_PERIOD - 1)) begin
      per_d = '0;
      tick  = 1'b1;
    end else begin
      per_d = per_q + 1'b1;
    end

    state_d     = state_q;
    idx_d       = idx_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    wait_d      = wait_q;
    req_valid_d = 1'b0;
    req_addr_d  = req_addr_q;
    done_d      = 1'b0;
    terr_d      = terr_q;
    take        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          take        = 1'b1;
          idx_d       = '0;
          req_valid_d = 1'b1;
          state_d     = S_REQ_LO;
        end
      end
      S_REQ_LO: begin
        wait_d  = '0;
        state_d = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (sys_resp_valid) begin
          lo_d        = sys_resp_data;
          req_valid_d = 1'b1;
          state_d     = S_REQ_HI;
        end else if (wait_q == WW'(TIMEOUT - 1)) begin
          terr_d  = 1'b1;
          state_d = S_NEXT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_REQ_HI: begin
        wait_d  = '0;
        state_d = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (sys_resp_valid) begin
          hi_d    = sys_resp_data;
          state_d = S_ACC;
        end else if (wait_q == WW'(TIMEOUT - 1)) begin
          terr_d  = 1'b1;
          state_d = S_NEXT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_ACC: begin
        state_d = S_NEXT;
      end
      S_NEXT: begin
        if (idx_q == IDX_W'(NUM_CNT - 1)) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          idx_d       = idx_q + 1'b1;
          req_valid_d = 1'b1;
          state_d     = S_REQ_LO;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Address is built from the next index so the strobe and address register together.
    if (req_valid_d) begin
      req_addr_d = '0;
      req_addr_d[ADDR_IDX_MSB:ADDR_IDX_LSB] = 7'(idx_d);
      req_addr_d[ADDR_BSEL] = (state_d == S_REQ_HI) ? BSEL_HI : BSEL_LO;
    end

    if (host_clr) begin
      terr_d = 1'b0;
    end

    pend_d = (pend_q & ~take) | tick | poll_kick;
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rstn_sys) begin
    if (!rstn_sys) begin
      state_q     <= S_IDLE;
      pend_q      <= 1'b0;
      idx_q       <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
      per_q       <= '0;
      wait_q      <= '0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      terr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      idx_q       <= idx_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      per_q       <= per_d;
      wait_q      <= wait_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      terr_q      <= terr_d;
    end
  end

  mgnt_cnt_bank #(
    .NUM_CNT (NUM_CNT),
    .IDX_W   (IDX_W)
  ) u_bank (
    .clk      (clk),
    .rstn_sys (rstn_sys),
    .clr      (host_clr),
    .acc_en   (state_q == S_ACC),
    .acc_idx  (idx_q),
    .acc_new  ({hi_q, lo_q}),
    .rd_idx   (host_rd_idx),
    .rd_data  (host_rd_data)
  );

  assign sys_req_valid = req_valid_q;
  assign sys_req_wr    = 1'b0;
  assign sys_req_addr  = req_addr_q;
  assign busy          = busy_q;
  assign sweep_done    = done_q;
  assign timeout_err   = terr_q;

endmodule

// File: tb/tb_mac_mgnt_poller.sv
// Scoreboard bench for mac_mgnt_poller: a byte responder models the MAC,
// expected request addresses and totals are queued and checked by a monitor.
module tb_mac_mgnt_poller;

  typedef struct {
    logic [1:0]  idx;
    logic [31:0] exp;
  } rd_exp_t;

  logic        clk = 1'b0;
  logic        rstn_sys = 1'b1;
  logic        sys_req_valid;
  logic        sys_req_wr;
  logic [7:0]  sys_req_addr;
  logic        sys_resp_valid;
  logic [7:0]  sys_resp_data;
  logic        poll_en = 1'b0;
  logic        poll_kick = 1'b0;
  logic        host_clr = 1'b0;
  logic [1:0]  host_rd_idx = 2'd0;
  logic [31:0] host_rd_data;
  logic        busy;
  logic        sweep_done;
  logic        timeout_err;

  logic        rsp_v = 1'b0;
  logic [7:0]  rsp_d = 8'h00;
  logic        stray_v = 1'b0;
  logic [7:0]  stray_d = 8'h00;
  logic [15:0] cnt [4];
  logic [3:0]  silent = 4'b0000;
  int          lat = 1;

  logic [7:0]  exp_addr_q [$];
  rd_exp_t     rd_q [$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          req_count = 0;

  assign sys_resp_valid = rsp_v | stray_v;
  assign sys_resp_data  = stray_v ? stray_d : rsp_d;

  always #5 clk = ~clk;

  mac_mgnt_poller #(
    .NUM_CNT     (4),
    .IDX_W       (2),
    .POLL_PERIOD (40),
    .TIMEOUT     (64)
  ) dut (
    .clk            (clk),
    .rstn_sys       (rstn_sys),
    .sys_req_valid  (sys_req_valid),
    .sys_req_wr     (sys_req_wr),
    .sys_req_addr   (sys_req_addr),
    .sys_resp_valid (sys_resp_valid),
    .sys_resp_data  (sys_resp_data),
    .poll_en        (poll_en),
    .poll_kick      (poll_kick),
    .host_clr       (host_clr),
    .host_rd_idx    (host_rd_idx),
    .host_rd_data   (host_rd_data),
    .busy           (busy),
    .sweep_done     (sweep_done),
    .timeout_err    (timeout_err)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // Responder: answers each request after 'lat' cycles unless its index is silent.
  initial begin : responder
    logic [7:0] a;
    logic [1:0] i;
    forever begin
      @(negedge clk);
      if (sys_req_valid && rstn_sys) begin
        a = sys_req_addr;
        i = a[2:1];
        if (!silent[i]) begin
          repeat (lat) @(posedge clk);
          #1;
          rsp_v = 1'b1;
          rsp_d = a[0] ? cnt[i][15:8] : cnt[i][7:0];
          @(posedge clk);
          #1 rsp_v = 1'b0;
        end
      end
    end
  end

  // Monitor: pops expected request addresses and read totals as the DUT presents them.
  always @(negedge clk) begin
    if (sys_req_valid) begin
      req_count++;
      check("req_wr", {31'b0, sys_req_wr}, 32'd0);
      if (exp_addr_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_req: got addr 0x%0h expected no request", sys_req_addr);
      end else begin
        check("req_addr", {24'b0, sys_req_addr}, {24'b0, exp_addr_q.pop_front()});
      end
    end
    if (rd_q.size() > 0) begin
      rd_exp_t e;
      e = rd_q.pop_front();
      check($sformatf("total%0d", e.idx), host_rd_data, e.exp);
    end
  end

  task automatic push_sweep(input logic [3:0] sil);
    for (int i = 0; i < 4; i++) begin
      exp_addr_q.push_back({5'b0, i[1:0], 1'b0});
      if (!sil[i]) exp_addr_q.push_back({5'b0, i[1:0], 1'b1});
    end
  endtask

  task automatic kick();
    @(posedge clk); #1 poll_kick = 1'b1;
    @(posedge clk); #1 poll_kick = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    logic ok;
    ok = 1'b0;
    for (int c = 0; c < bound && !ok; c++) begin
      @(negedge clk);
      if (sweep_done) ok = 1'b1;
    end
    check("sweep_done_seen", {31'b0, ok}, 32'd1);
  endtask

  task automatic wait_req(input logic [7:0] addr);
    logic ok;
    ok = 1'b0;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(negedge clk);
      if (sys_req_valid && sys_req_addr == addr) ok = 1'b1;
    end
    check("req_seen", {31'b0, ok}, 32'd1);
  endtask

  task automatic rd_check(input logic [1:0] idx, input logic [31:0] exp);
    rd_exp_t e;
    @(posedge clk); #1 host_rd_idx = idx;
    @(posedge clk); #1;
    e.idx = idx;
    e.exp = exp;
    rd_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic sweep(input logic [3:0] sil);
    push_sweep(sil);
    kick();
    wait_done(400);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_req_valid"}, {31'b0, sys_req_valid}, 32'd0);
    check({tag, "_req_addr"}, {24'b0, sys_req_addr}, 32'd0);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_done"}, {31'b0, sweep_done}, 32'd0);
    check({tag, "_terr"}, {31'b0, timeout_err}, 32'd0);
    check({tag, "_rd_data"}, host_rd_data, 32'd0);
  endtask

  initial begin : stim
    int rc0;
    cnt[0] = 16'h1234; cnt[1] = 16'h0011; cnt[2] = 16'h00A0; cnt[3] = 16'h0002;
    #1 rstn_sys = 1'b0;
    #20 check_zero_outputs("reset");
    @(posedge clk); #1 rstn_sys = 1'b1;
    repeat (2) @(posedge clk);

    // Basic sweep then a second sweep on idx0.
    sweep(4'b0000);
    rd_check(2'd0, 32'h0000_1234);
    rd_check(2'd1, 32'h0000_0011);
    rd_check(2'd2, 32'h0000_00A0);
    rd_check(2'd3, 32'h0000_0002);
    check("busy_after_sweep", {31'b0, busy}, 32'd0);
    cnt[0] = 16'h1300;
    sweep(4'b0000);
    rd_check(2'd0, 32'h0000_1300);
    rd_check(2'd1, 32'h0000_0011);

    // Wrap of the hardware counter.
    cnt[0] = 16'hFFF0;
    sweep(4'b0000);
    rd_check(2'd0, 32'h0000_FFF0);
    cnt[0] = 16'h0010;
    sweep(4'b0000);
    rd_check(2'd0, 32'h0001_0010);

    // Timeout on idx2: its total and last stay put, idx3 is still polled.
    silent = 4'b0100;
    cnt[2] = 16'h00B0;
    cnt[3] = 16'h0007;
    sweep(4'b0100);
    check("timeout_err_set", {31'b0, timeout_err}, 32'd1);
    rd_check(2'd2, 32'h0000_00A0);
    rd_check(2'd3, 32'h0000_0007);
    silent = 4'b0000;
    sweep(4'b0000);
    rd_check(2'd2, 32'h0000_00B0);
    check("timeout_err_sticky", {31'b0, timeout_err}, 32'd1);

    // Several kicks while busy collapse into one extra sweep.
    rc0 = req_count;
    push_sweep(4'b0000);
    push_sweep(4'b0000);
    kick();
    repeat (3) @(posedge clk);
    repeat (3) kick();
    wait_done(400);
    wait_done(400);
    repeat (20) @(posedge clk);
    #1 check("collapse_req_count", req_count - rc0, 32'd16);
    check("collapse_idle", {31'b0, busy}, 32'd0);
    rd_check(2'd0, 32'h0001_0010);

    // Clear in the ACC cycle of idx1 wins; last1 still advances to 0x0005.
    cnt[1] = 16'h0005;
    push_sweep(4'b0000);
    kick();
    wait_req(8'h03);
    @(posedge clk); #1;
    @(posedge clk); #1 host_clr = 1'b1;
    @(posedge clk); #1 host_clr = 1'b0;
    wait_done(400);
    rd_check(2'd1, 32'h0000_0000);
    rd_check(2'd0, 32'h0000_0000);
    check("clr_terr", {31'b0, timeout_err}, 32'd0);
    cnt[1] = 16'h0008;
    sweep(4'b0000);
    rd_check(2'd1, 32'h0000_0003);

    // Stray response while idle.
    @(posedge clk); #1 stray_v = 1'b1; stray_d = 8'hFF;
    @(posedge clk); #1 stray_v = 1'b0;
    repeat (5) @(posedge clk);
    #1 check("stray_idle_busy", {31'b0, busy}, 32'd0);
    rd_check(2'd1, 32'h0000_0003);

    // Periodic tick starts a sweep without a kick.
    push_sweep(4'b0000);
    @(posedge clk); #1 poll_en = 1'b1;
    wait_done(300);
    @(posedge clk); #1 poll_en = 1'b0;
    rd_check(2'd1, 32'h0000_0003);

    // Async reset while waiting for the high byte of idx0.
    lat = 5;
    exp_addr_q.push_back(8'h00);
    exp_addr_q.push_back(8'h01);
    kick();
    wait_req(8'h01);
    @(posedge clk); #1 rstn_sys = 1'b0;
    #1 check_zero_outputs("midsweep");
    repeat (10) @(posedge clk);
    #1 rstn_sys = 1'b1;
    lat = 1;
    repeat (5) @(posedge clk);
    #1 check("post_reset_busy", {31'b0, busy}, 32'd0);
    rd_check(2'd0, 32'h0000_0000);
    rd_check(2'd3, 32'h0000_0000);
    sweep(4'b0000);
    rd_check(2'd0, 32'h0000_0010);
    rd_check(2'd1, 32'h0000_0008);
    rd_check(2'd2, 32'h0000_00B0);
    rd_check(2'd3, 32'h0000_0007);
    check("scoreboard_drained", exp_addr_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
